// File: rtl/udma_pwr_seq_pkg.sv
// udma_pwr_seq_pkg: shared types for the uDMA peripheral power sequencer
package udma_pwr_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_UP_WAIT, ST_DN_WAIT} pwr_seq_state_e;
  typedef enum logic {DIR_DOWN, DIR_UP} pwr_dir_e;
endpackage

// File: rtl/udma_pwr_rr_arb.sv
// udma_pwr_rr_arb: round-robin pick of the first pending index at or after the pointer
module udma_pwr_rr_arb #(
  parameter int N     = 6,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N-1:0]     i_pending,
  input  logic             i_accept,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);
  logic [IDX_W-1:0] r_ptr;
  int w_j;
  // Scan offsets from farthest to nearest so the nearest pending index wins
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx = '0;
    w_j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(r_ptr) + k) % N;
      if (i_pending[w_j]) begin
        o_grant_valid = 1'b1;
        o_grant_idx = IDX_W'(w_j);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_ptr <= '0;
    else if (i_accept) r_ptr <= (o_grant_idx == IDX_W'(N - 1)) ? '0 : o_grant_idx + IDX_W'(1);
endmodule

// File: rtl/udma_pwr_seq.sv
// udma_pwr_seq: one-at-a-time clock-gate / reset sequencing for uDMA peripherals
// Up: clock on, settle, release reset. Down: assert reset, hold, clock off.
module udma_pwr_seq
  import udma_pwr_seq_pkg::*;
#(
  parameter int N_PERIPHS = 6,
  parameter int DLY_W     = 8,
  localparam int IDX_W    = $clog2(N_PERIPHS)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N_PERIPHS-1:0] en_req_i,
  input  logic [DLY_W-1:0]     cfg_cg_settle_i,
  input  logic [DLY_W-1:0]     cfg_rst_hold_i,
  output logic [N_PERIPHS-1:0] cg_o,
  output logic [N_PERIPHS-1:0] rst_o,
  output logic                 cg_core_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IDX_W-1:0]     done_idx_o,
  output logic                 done_on_o
);
  pwr_seq_state_e r_state, w_state_nxt;
  pwr_dir_e r_dir;
  logic [DLY_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx, r_done_idx;
  logic [N_PERIPHS-1:0] r_cg, r_rst;
  logic r_done, r_done_on;
  logic w_gnt_vld, w_accept, w_fin, w_up;
  logic [IDX_W-1:0] w_gnt_idx;
  // A peripheral is pending exactly when its request disagrees with its clock state
  udma_pwr_rr_arb #(.N(N_PERIPHS), .IDX_W(IDX_W)) u_arb (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .i_pending    (en_req_i ^ r_cg),
    .i_accept     (w_accept),
    .o_grant_valid(w_gnt_vld),
    .o_grant_idx  (w_gnt_idx)
  );
  always_comb begin
    w_up = en_req_i[w_gnt_idx];
    w_accept = (r_state == ST_IDLE) && w_gnt_vld;
    w_fin = (r_state != ST_IDLE) && (r_cnt == '0);
    w_state_nxt = w_accept ? (w_up ? ST_UP_WAIT : ST_DN_WAIT) : w_fin ? ST_IDLE : r_state;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_dir <= DIR_DOWN;
      r_cnt <= '0;
      r_idx <= '0;
      r_cg <= '0;
      r_rst <= '1;
      r_done <= 1'b0;
      r_done_idx <= '0;
      r_done_on <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done <= w_fin;
      if (w_accept) begin
        r_idx <= w_gnt_idx;
        r_dir <= w_up ? DIR_UP : DIR_DOWN;
        r_cnt <= w_up ? cfg_cg_settle_i : cfg_rst_hold_i;
        if (w_up) r_cg[w_gnt_idx] <= 1'b1;
        else r_rst[w_gnt_idx] <= 1'b1;
      end else if (r_cnt != '0) r_cnt <= r_cnt - DLY_W'(1);
      if (w_fin) begin
        r_done_idx <= r_idx;
        r_done_on <= (r_dir == DIR_UP);
        if (r_dir == DIR_UP) r_rst[r_idx] <= 1'b0;
        else r_cg[r_idx] <= 1'b0;
      end
    end
  assign cg_o = r_cg;
  assign rst_o = r_rst;
  assign cg_core_o = |r_cg;
  assign busy_o = (r_state != ST_IDLE);
  assign done_o = r_done;
  assign done_idx_o = r_done_idx;
  assign done_on_o = r_done_on;
endmodule

// File: tb/tb_udma_pwr_seq.sv
// tb_udma_pwr_seq: directed scoreboard bench for the uDMA power sequencer
module tb_udma_pwr_seq;
  localparam int N = 6, DW = 8, IW = 3;
  logic clk_i = 1'b0, rstn_i = 1'b0;
  logic [N-1:0] en_req_i = '0;
  logic [DW-1:0] cfg_cg_settle_i = '0, cfg_rst_hold_i = '0;
  logic [N-1:0] cg_o, rst_o;
  logic cg_core_o, busy_o, done_o, done_on_o;
  logic [IW-1:0] done_idx_o;

  udma_pwr_seq dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_req_i(en_req_i),
    .cfg_cg_settle_i(cfg_cg_settle_i), .cfg_rst_hold_i(cfg_rst_hold_i),
    .cg_o(cg_o), .rst_o(rst_o), .cg_core_o(cg_core_o), .busy_o(busy_o),
    .done_o(done_o), .done_idx_o(done_idx_o), .done_on_o(done_on_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [IW-1:0] idx; logic on;} exp_t;
  exp_t q[$];
  exp_t m_exp;
  int checks = 0, errors = 0, cyc = 0;
  bit sb_en = 1'b1;
  logic [2*N-1:0] prev = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard monitor: every completion pulse must match the oldest expected entry
  always @(negedge clk_i)
    if (rstn_i && done_o && sb_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL done_extra: got idx=%0d on=%0d, required no completion", done_idx_o, done_on_o);
      end else begin
        m_exp = q.pop_front();
        if (done_idx_o !== m_exp.idx || done_on_o !== m_exp.on) begin
          errors++;
          $display("FAIL done_event: got idx=%0d on=%0d, required idx=%0d on=%0d",
                   done_idx_o, done_on_o, m_exp.idx, m_exp.on);
        end
      end
    end

  // Invariants hold in every cycle out of reset
  always @(negedge clk_i) begin
    if (rstn_i) begin
      checks++;
      if ((~rst_o & ~cg_o) != '0) begin
        errors++;
        $display("FAIL inv_rst_cg: got cg=%0h rst=%0h, required rst=0 only where cg=1", cg_o, rst_o);
      end
      checks++;
      if ($countones({cg_o, rst_o} ^ prev) > 1) begin
        errors++;
        $display("FAIL inv_one_change: got %0h -> %0h, required at most one bit change", prev, {cg_o, rst_o});
      end
      checks++;
      if (cg_core_o !== |cg_o) begin
        errors++;
        $display("FAIL inv_cg_core: got %0b, required %0b", cg_core_o, |cg_o);
      end
    end
    prev = {cg_o, rst_o};
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push(input int i, input bit on);
    exp_t e;
    e.idx = IW'(i);
    e.on = on;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk_i);
      if (!busy_o && en_req_i === cg_o) break;
    end
    @(negedge clk_i);
    chk({name, "_timeout"}, (k < 3000) ? 32'd1 : 32'd0, 32'd1);
    chk({name, "_sb_empty"}, q.size(), 0);
  endtask

  // Edges from the first transition of a sequence to its second one
  task automatic gap(input int i, input bit up, output int d);
    int t0;
    t0 = -1;
    d = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_i);
      if (t0 < 0 && (up ? cg_o[i] : rst_o[i])) t0 = cyc;
      if (t0 >= 0 && (up ? !rst_o[i] : !cg_o[i])) begin
        d = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    int d, t0;
    int t[N];
    logic [N-1:0] pc;
    repeat (3) @(negedge clk_i);
    chk("rst_cg", cg_o, 0);
    chk("rst_rst", rst_o, 6'h3F);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_done_idx", done_idx_o, 0);
    chk("rst_done_on", done_on_o, 0);
    chk("rst_cg_core", cg_core_o, 0);
    rstn_i = 1'b1;
    // Round-robin from pointer 0, settle 0: grants 0..5 spaced settle+2 edges
    for (int i = 0; i < N; i++) begin t[i] = -100; push(i, 1); end
    pc = cg_o;
    en_req_i = 6'h3F;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      for (int i = 0; i < N; i++) if (cg_o[i] && !pc[i]) t[i] = cyc;
      pc = cg_o;
      if (cg_o == 6'h3F) break;
    end
    for (int i = 1; i < N; i++) chk("rr_spacing", t[i] - t[i-1], 2);
    wait_idle("rr_up");
    chk("rr_final_cg", cg_o, 6'h3F);
    chk("rr_final_rst", rst_o, 0);
    for (int i = 0; i < N; i++) push(i, 0);
    en_req_i = '0;
    wait_idle("rr_down");
    // Move the pointer to 4 by cycling index 3 alone
    push(3, 1);
    en_req_i = 6'h08;
    wait_idle("p3_up");
    push(3, 0);
    en_req_i = '0;
    wait_idle("p3_down");
    push(4, 1); push(5, 1); push(0, 1); push(1, 1); push(2, 1); push(3, 1);
    en_req_i = 6'h3F;
    wait_idle("rr4_up");
    push(4, 0); push(5, 0); push(0, 0); push(1, 0); push(2, 0); push(3, 0);
    en_req_i = '0;
    wait_idle("rr4_down");
    // Power-up with settle 3
    cfg_cg_settle_i = 8'd3;
    push(2, 1);
    en_req_i = 6'h04;
    gap(2, 1'b1, d);
    chk("up_gap", d, 4);
    chk("up_done", done_o, 1);
    chk("up_done_idx", done_idx_o, 2);
    chk("up_done_on", done_on_o, 1);
    wait_idle("up");
    // Power-down with hold 0
    cfg_rst_hold_i = 8'd0;
    push(2, 0);
    en_req_i = '0;
    gap(2, 1'b0, d);
    chk("dn_gap", d, 1);
    chk("dn_done_on", done_on_o, 0);
    wait_idle("dn");
    chk("done_idx_hold", done_idx_o, 2);
    // Request dropped mid-sequence; a second request appears and vanishes before grant
    cfg_cg_settle_i = 8'd10;
    cfg_rst_hold_i = 8'd2;
    push(1, 1); push(1, 0);
    en_req_i = 6'h02;
    t0 = -1;
    for (int k = 0; k < 20 && t0 < 0; k++) begin
      @(negedge clk_i);
      if (cg_o[1]) t0 = cyc;
    end
    @(negedge clk_i);
    en_req_i = 6'h12;
    cfg_cg_settle_i = 8'd200;
    repeat (2) @(negedge clk_i);
    en_req_i = '0;
    d = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (!rst_o[1]) begin d = cyc - t0; break; end
    end
    chk("toggle_up_gap", d, 11);
    wait_idle("toggle");
    chk("toggle_cg", cg_o, 0);
    chk("toggle_rst", rst_o, 6'h3F);
    // Random requests and delays; only the invariants are judged here
    sb_en = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk_i);
      if ($urandom_range(7) == 0) en_req_i = 6'($urandom);
      cfg_cg_settle_i = 8'($urandom_range(7));
      cfg_rst_hold_i = 8'($urandom_range(7));
    end
    en_req_i = '0;
    wait_idle("rand");
    sb_en = 1'b1;
    chk("rand_cg", cg_o, 0);
    chk("rand_rst", rst_o, 6'h3F);
    // Asynchronous reset in the middle of a long sequence
    cfg_cg_settle_i = 8'd100;
    en_req_i = 6'h01;
    repeat (5) @(negedge clk_i);
    chk("mid_busy", busy_o, 1);
    chk("mid_cg", cg_o, 6'h01);
    rstn_i = 1'b0;
    #1;
    chk("async_cg", cg_o, 0);
    chk("async_rst", rst_o, 6'h3F);
    chk("async_busy", busy_o, 0);
    chk("async_done", done_o, 0);
    chk("async_cg_core", cg_core_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
